spwm_3ph_gen: RTL

Parametrised three-phase sinusoidal PWM generator driving one motor channel's six gate signals: three high-side outputs and three complementary low-side outputs. It adds four things the fixed 8-bit generator lacks:
- a phase-accumulator frequency word for fine frequency control;
- amplitude scaling;
- per-phase dead-time insertion;
- shadow-registered duty updates at the carrier boundary.

Instantiated once per channel inside the multi-channel motor driver top, on the system clock.

---
 rtl/spwm_3ph_gen.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/spwm_3ph_gen.sv
// spwm_3ph_gen: three-phase sine PWM for one motor channel.
// A phase accumulator steps once per 256-clock carrier period. Amplitude scales
// the sine samples, and each phase has its own dead-time inserter. Parameters
// and duties are shadowed and only take effect at the carrier boundary.

// One phase: amplitude-scaled duty, shadowed duty, compare and dead-time.
module spwm_phase #(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            first,
  input  logic            load,
  input  logic [7:0]      sine,
  input  logic [8:0]      amp_l,
  input  logic [DT_W-1:0] dt_l,
  input  logic [7:0]      cnt,
  output logic            out,
  output logic            out_inv
);
  logic signed [16:0] diff, gain, prod;
  logic [7:0]         duty_calc, duty_next, duty_active;
  logic               raw, lvl;
  logic [DT_W-1:0]    dtc;

  // Centre the sample on 127, scale by amp/256 with floor, re-centre.
  assign diff      = $signed({9'd0, sine}) - 17'sd127;
  assign gain      = $signed({8'd0, amp_l});
  assign prod      = diff * gain;
  assign duty_calc = 8'(prod >>> 8) + 8'd127;
  assign raw       = (cnt < duty_active);

  // duty_next tracks acc/amp every cycle; duty_active only moves on load.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_next   <= '0;
      duty_active <= '0;
    end else begin
      duty_next <= duty_calc;
      if (load) duty_active <= duty_next;
    end
  end

  // Dead-time: any raw change blanks both gates and restarts the countdown.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      lvl     <= 1'b0;
      dtc     <= '0;
      out     <= 1'b0;
      out_inv <= 1'b0;
    end else if (first || raw != lvl) begin
      lvl     <= raw;
      dtc     <= dt_l;
      out     <= (dt_l == '0) & raw;
      out_inv <= (dt_l == '0) & ~raw;
    end else if (dtc != '0) begin
      dtc     <= dtc - DT_W'(1);
      out     <= (dtc == DT_W'(1)) & lvl;
      out_inv <= (dtc == DT_W'(1)) & ~lvl;
    end else begin
      out     <= lvl;
      out_inv <= ~lvl;
    end
  end
endmodule

module spwm_3ph_gen #(
  parameter int ACC_W = 24,
  parameter int DT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [ACC_W-1:0] freq_word,
  input  logic [8:0]       amp,
  input  logic [DT_W-1:0]  dead_time,
  output logic             out_p1,
  output logic             out_p2,
  output logic             out_p3,
  output logic             out_p1_inv,
  output logic             out_p2_inv,
  output logic             out_p3_inv,
  output logic             period_tick
);
  localparam int NUM_PH = 3;
  localparam logic [NUM_PH-1:0][7:0] PH_OFS = {8'd171, 8'd85, 8'd0};

  // Full 256-entry sine table, evaluated at elaboration.
  function automatic logic [255:0][7:0] build_sine();
    logic [255:0][7:0] t;
    real v;
    for (int i = 0; i < 256; i++) begin
      v = 127.0 + 127.0 * $sin(2.0 * 3.141592653589793 * real'(i) / 256.0);
      t[i] = 8'($rtoi(v + 0.5));
    end
    return t;
  endfunction

  localparam logic [255:0][7:0] SINE_LUT = build_sine();

  logic [7:0]              cnt;
  logic [ACC_W-1:0]        acc, fw_l;
  logic [8:0]              amp_l, amp_sat;
  logic [DT_W-1:0]         dt_l;
  logic                    en_d, boundary, load, first;
  logic [NUM_PH-1:0][7:0]  addr, sine;
  logic [NUM_PH-1:0]       hs, ls;

  assign amp_sat  = (amp > 9'd256) ? 9'd256 : amp;
  assign boundary = en && (cnt == 8'hFF);
  // While disabled the shadows follow the inputs so the first enabled period is valid.
  assign load     = !en || boundary;
  assign first    = en && !en_d;

  // Carrier counter, boundary tick and enable history.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      period_tick <= 1'b0;
      en_d        <= 1'b0;
    end else begin
      cnt         <= en ? cnt + 8'd1 : 8'd0;
      period_tick <= boundary;
      en_d        <= en;
    end
  end

  // Phase accumulator and shadowed parameters.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      fw_l  <= '0;
      amp_l <= '0;
      dt_l  <= '0;
    end else begin
      if (boundary) acc <= acc + fw_l;
      if (load) begin
        fw_l  <= freq_word;
        amp_l <= amp_sat;
        dt_l  <= dead_time;
      end
    end
  end

  for (genvar g = 0; g < NUM_PH; g++) begin : g_ph
    assign addr[g] = acc[ACC_W-1 -: 8] + PH_OFS[g];
    assign sine[g] = SINE_LUT[addr[g]];

    spwm_phase #(.DT_W(DT_W)) u_ph (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .first   (first),
      .load    (load),
      .sine    (sine[g]),
      .amp_l   (amp_l),
      .dt_l    (dt_l),
      .cnt     (cnt),
      .out     (hs[g]),
      .out_inv (ls[g])
    );
  end

  assign out_p1     = hs[0];
  assign out_p2     = hs[1];
  assign out_p3     = hs[2];
  assign out_p1_inv = ls[0];
  assign out_p2_inv = ls[1];
  assign out_p3_inv = ls[2];
endmodule
